// File: rtl/seq_mult8_shift_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult8_shift_add_if
//  Description : Operand/product valid-ready bundle for seq_mult8_shift_add.
//                The master side supplies operands and accepts products.
//                The slave side is the multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_mult8_shift_add_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_mult8_shift_add.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult8_shift_add
//  Description : Sequential 8x8 unsigned shift-and-add multiplier.
//                It reuses a single 8-bit carry-skip adder, with one add per cycle.
//                Operands arrive over a valid/ready port.
//                The 16-bit product leaves over a valid/ready port.
//                Optional macro EARLY_TERM_EN: finish CALC as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult8_shift_add #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_mult8_shift_add_if.slave    bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_a_n;
    logic               w_c_n;
    logic [2*WIDTH:0]   w_full;
    logic [2*WIDTH:0]   w_next;
    logic               w_done;
    logic               w_out_valid;

    // Carry-skip adder A+M (cin=0): 4-bit ripple blocks, with a skip path
    // that passes the block carry-in straight through when every bit propagates.
    always_comb begin : adder
        logic v_carry;
        logic v_blk_cin;
        logic v_prop;
        v_carry   = 1'b0;
        v_blk_cin = 1'b0;
        v_prop    = 1'b0;
        w_sum     = '0;
        for (int blk = 0; blk < WIDTH / 4; blk++) begin
            v_blk_cin = v_carry;
            v_prop    = 1'b1;
            for (int i = 0; i < 4; i++) begin
                w_sum[blk*4+i] = r_a[blk*4+i] ^ r_m[blk*4+i] ^ v_carry;
                v_carry = (r_a[blk*4+i] & r_m[blk*4+i]) |
                          (v_carry & (r_a[blk*4+i] ^ r_m[blk*4+i]));
                v_prop  = v_prop & (r_a[blk*4+i] ^ r_m[blk*4+i]);
            end
            if (v_prop) begin
                v_carry = v_blk_cin;
            end
        end
        w_cout = v_carry;
    end

    // One iteration: conditionally add M, then form the unshifted {C,A,Q}.
    // r_c is always zero between iterations, because the previous shift moved it into A[7].
    assign w_a_n  = r_q[0] ? w_sum  : r_a;
    assign w_c_n  = r_q[0] ? w_cout : r_c;
    assign w_full = {w_c_n, w_a_n, r_q};

`ifdef EARLY_TERM_EN
    logic [WIDTH-1:0]   w_mask;
    logic               w_rest_zero;

    // After this iteration the unprocessed multiplier bits are Q[cnt-1:1].
    // If they are all zero, shift the remaining cnt positions in one step.
    assign w_mask      = (WIDTH'(1) << (r_cnt - CNT_W'(1))) - WIDTH'(1);
    assign w_rest_zero = (((r_q >> 1) & w_mask) == '0);
    assign w_done      = w_rest_zero;
    assign w_next      = w_rest_zero ? (w_full >> r_cnt) : (w_full >> 1);
`else
    assign w_done = (r_cnt == CNT_W'(1));
    assign w_next = w_full >> 1;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_m     <= bus.a;
                        r_q     <= bus.b;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_c   <= w_next[2*WIDTH];
                    r_a   <= w_next[2*WIDTH-1:WIDTH];
                    r_q   <= w_next[WIDTH-1:0];
                    r_cnt <= w_done ? '0 : (r_cnt - CNT_W'(1));
                    if (w_done) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from state.
    // The product is forced to zero outside DONE, so it reads zero in reset.
    assign w_out_valid   = (r_state == c_DONE);
    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.product   = w_out_valid ? {r_a, r_q} : '0;

endmodule
`default_nettype wire
